// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache (byte CPU port, 32-bit block memory port).
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int TAG_BITS    = 6 - INDEX_BITS;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int BLOCK_BYTES = 4;
  localparam int OFF_BITS    = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FETCH
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_first;

  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [OFF_BITS-1:0]   w_off;
  logic [4:0]            w_bit;
  logic [31:0]           w_line;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_done;
  logic                  w_fill;
  logic                  w_wr_hit;

  assign w_tag  = ADDRESS[7 -: TAG_BITS];
  assign w_idx  = ADDRESS[OFF_BITS +: INDEX_BITS];
  assign w_off  = ADDRESS[OFF_BITS-1:0];
  assign w_bit  = {w_off, 3'b000};
  assign w_line = r_data[w_idx];
  assign w_req  = READ | WRITE;
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A transfer may only finish once memory has seen the request for a cycle.
  assign w_done = ~MEM_BUSYWAIT & ~r_first;

  // Next state, CPU stall, and memory-side request outputs.
  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    READDATA      = 8'h00;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    w_fill        = 1'b0;
    w_wr_hit      = 1'b0;
    if (!RESET) begin
      BUSYWAIT = w_req & ~((r_state == S_IDLE) & w_hit);
      READDATA = READ ? w_line[w_bit +: 8] : 8'h00;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              w_wr_hit = WRITE;
            end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
              w_next = S_WB;
            end else begin
              w_next = S_FETCH;
            end
          end
        end
        S_WB: begin
          MEM_WRITE     = 1'b1;
          MEM_ADDRESS   = {r_tag[w_idx], w_idx};
          MEM_WRITEDATA = w_line;
          if (w_done) w_next = S_FETCH;
        end
        S_FETCH: begin
          MEM_READ    = 1'b1;
          MEM_ADDRESS = {w_tag, w_idx};
          if (w_done) begin
            w_fill = 1'b1;
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register plus first-cycle-in-state flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  // Line status bits; reset drops all lines, discarding dirty data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Line tag and data: refill a whole block or merge one written byte.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_idx] <= MEM_READDATA;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_bit +: 8] <= WRITEDATA;
    end
  end

`ifdef DCACHE_STATS_EN
  logic r_refill;

  // Marks the cycle right after a refill so the completing access is not a hit.
  always_ff @(posedge CLK) begin
    if (RESET) r_refill <= 1'b0;
    else       r_refill <= w_fill;
  end

  // Saturating hit and miss counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= 16'h0;
      MISS_COUNT <= 16'h0;
    end else begin
      if ((r_state == S_IDLE) && w_req && w_hit && !r_refill
          && (HIT_COUNT != 16'hFFFF))
        HIT_COUNT <= HIT_COUNT + 16'h1;
      if ((r_state == S_IDLE) && (w_next != S_IDLE)
          && (MISS_COUNT != 16'hFFFF))
        MISS_COUNT <= MISS_COUNT + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for dcache_direct_mapped: directed scenarios then random traffic
// against a flat byte-array model of memory contents.
module tb_dcache_direct_mapped;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dcache_direct_mapped dut (
    .CLK          (clk),
    .RESET        (rst),
    .READ         (rd),
    .WRITE        (wr),
    .ADDRESS      (addr),
    .WRITEDATA    (wdata),
    .READDATA     (rdata),
    .BUSYWAIT     (busy),
    .MEM_READ     (mem_rd),
    .MEM_WRITE    (mem_wr),
    .MEM_ADDRESS  (mem_addr),
    .MEM_WRITEDATA(mem_wdata),
    .MEM_READDATA (mem_rdata),
    .MEM_BUSYWAIT (mem_busy)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT    (hit_cnt),
    .MISS_COUNT   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [64];
  logic [7:0]  ref_mem [256];
  logic [7:0]  sbq[$];

  int n_chk;
  int n_fail;
  int mcnt;
  int mr_cycles;
  int mw_cycles;
  logic [5:0]  mr_addr;
  logic [5:0]  mw_addr;
  logic [31:0] mw_data;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_block(logic [5:0] b);
    return {ref_mem[{b, 2'd3}], ref_mem[{b, 2'd2}],
            ref_mem[{b, 2'd1}], ref_mem[{b, 2'd0}]};
  endfunction

  task automatic resync_ref();
    for (int i = 0; i < 64; i++) begin
      ref_mem[i*4]   = mem[i][7:0];
      ref_mem[i*4+1] = mem[i][15:8];
      ref_mem[i*4+2] = mem[i][23:16];
      ref_mem[i*4+3] = mem[i][31:24];
    end
  endtask

  // Issue one CPU access, push the expected read byte, wait for completion.
  task automatic do_op(input logic w, input logic [7:0] a,
                       input logic [7:0] d, output int stalls);
    bit ok;
    if (w) ref_mem[a] = d;
    else   sbq.push_back(ref_mem[a]);
    addr  = a;
    wdata = d;
    rd    = ~w;
    wr    = w;
    stalls = 0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) chk("op_timeout", 0, 1);
    @(posedge clk);
    #1;
    rd = 0;
    wr = 0;
  endtask

  // Memory responder with N wait cycles, plus the read-data scoreboard monitor.
  task automatic mem_and_monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        chk("mem_rd_wr_excl", {31'b0, mem_rd & mem_wr}, 0);
        if (mem_rd) begin
          mr_cycles++;
          mr_addr = mem_addr;
        end
        if (mem_wr) begin
          mw_cycles++;
          mw_addr = mem_addr;
          mw_data = mem_wdata;
        end
        if (mcnt == N) begin
          mem_busy = 0;
          if (mem_wr) begin
            chk("wb_data", mem_wdata, ref_block(mem_addr));
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
          end
          mcnt = 0;
        end else begin
          mem_busy = 1;
          mcnt++;
        end
      end else begin
        mem_busy = 0;
        mcnt = 0;
      end
      if (!rst && rd && !busy) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_read", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("readdata", {24'b0, rdata}, {24'b0, e});
        end
      end
    end
  endtask

  initial begin
    int st;
    int mr0;
    int mw0;
    bit seen;
    n_chk = 0;
    n_fail = 0;
    mcnt = 0;
    mr_cycles = 0;
    mw_cycles = 0;
    mr_addr = 0;
    mw_addr = 0;
    mw_data = 0;
    mem_busy = 0;
    mem_rdata = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    rst = 1;
    rd = 1;
    wr = 0;
    addr = 8'h05;
    wdata = 0;
    fork
      mem_and_monitor();
    join_none

    // Outputs are forced quiet while reset is held, even with a request present.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busywait", {31'b0, busy}, 0);
    chk("rst_readdata", {24'b0, rdata}, 0);
    chk("rst_mem_read", {31'b0, mem_rd}, 0);
    chk("rst_mem_write", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", {26'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 0;
    rd = 0;
    resync_ref();

    // Cold read miss.
    mr0 = mr_cycles;
    do_op(0, 8'h05, 0, st);
    chk("cold_stall", st, N + 2);
    chk("cold_mem_read_cycles", mr_cycles - mr0, N + 1);
    chk("cold_mem_addr", {26'b0, mr_addr}, 32'h01);

    // Read hits in the same line.
    mr0 = mr_cycles;
    do_op(0, 8'h05, 0, st);
    chk("hit1_stall", st, 0);
    do_op(0, 8'h06, 0, st);
    chk("hit2_stall", st, 0);
    chk("hit_no_mem_read", mr_cycles - mr0, 0);

    // Write hit dirties the line; conflicting read forces write-back then fetch.
    do_op(1, 8'h05, 8'hAB, st);
    chk("whit_stall", st, 0);
    mw0 = mw_cycles;
    do_op(0, 8'h25, 0, st);
    chk("wb_cycles", mw_cycles - mw0, N + 1);
    chk("wb_addr", {26'b0, mw_addr}, 32'h01);
    chk("wb_block", mw_data, 32'h4433AB11);
    chk("wb_fetch_addr", {26'b0, mr_addr}, 32'h09);
`ifdef DCACHE_STATS_EN
    chk("hit_count", {16'b0, hit_cnt}, 3);
    chk("miss_count", {16'b0, miss_cnt}, 2);
`endif

    // Write miss allocates then merges; line stays dirty.
    do_op(1, 8'h40, 8'h7E, st);
    chk("wmiss_stall", st, N + 2);
    do_op(0, 8'h40, 0, st);
    chk("wmerge_read_stall", st, 0);
    mw0 = mw_cycles;
    do_op(0, 8'h00, 0, st);
    chk("wmerge_dirty_wb", mw_cycles - mw0, N + 1);
    chk("wmerge_wb_addr", {26'b0, mw_addr}, 32'h10);
    chk("wmerge_wb_byte", {24'b0, mw_data[7:0]}, 32'h7E);

    // Leave dirty data behind, then reset in the middle of a refill.
    do_op(1, 8'h0C, 8'h55, st);
    addr = 8'h85;
    rd = 1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_rd) begin
        seen = 1;
        break;
      end
    end
    chk("rst_fetch_seen", {31'b0, seen}, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_mem_read", {31'b0, mem_rd}, 0);
    chk("post_rst_idle_miss", {31'b0, busy}, 1);
    rd = 0;
    @(posedge clk);
    #1;
    resync_ref();
    do_op(0, 8'h85, 0, st);
    chk("post_rst_remiss", st, N + 2);
    do_op(0, 8'h0C, 0, st);
    chk("post_rst_dirty_dropped", st, N + 2);

    // Random traffic against the flat memory model.
    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom), st);
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
